qeu_bank_mem: RTL and testbench

QEU_BANK_MEM -- requirements
Module: qeu_bank_mem

---
 rtl/qeu_pkg.sv | 21 ++
 rtl/qeu_bank_ram.sv | 28 ++
 rtl/qeu_bank_mem.sv | 207 ++++++++++++++++++++
 tb/tb_qeu_bank_mem.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qeu_pkg.sv
// Shared definitions for the query bank ring: load FSM encoding and the
// width helpers used to size bank indices and the fill counter.
package qeu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  // Width of a bank index; a single bank still needs one bit.
  function automatic int bank_idx_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  // Width of a counter that must hold 0..num_banks inclusive.
  function automatic int fill_cnt_w(input int num_banks);
    return $clog2(num_banks + 1);
  endfunction

endpackage

// File: rtl/qeu_bank_ram.sv
// One query bank: single-port RAM, write-enable plus shared address,
// registered read data (1-cycle latency). Contents are never reset.
module qeu_bank_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_q;

  // Write port and registered read port share one address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout_q <= mem[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/qeu_bank_mem.sv
// Ring of NUM_BANKS query banks. A load FSM fills the bank at wr_bank from
// a FWFT source FIFO; the consumer reads the bank at rd_bank and releases
// it with qeu_next. Both indices wrap independently around the ring.
module qeu_bank_mem
  import qeu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_BANKS = 4,
  parameter int QEU_DEPTH = 1616,
  parameter int PTR_WIDTH = $clog2(QEU_DEPTH),
  parameter int CNT_WIDTH = fill_cnt_w(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_cmd,
  input  logic [PTR_WIDTH:0]   load_len,
  input  logic                 load_abort,
  input  logic                 src_fifo_empty,
  input  logic [31:0]          src_fifo_data,
  output logic                 src_fifo_rden,
  output logic                 src_fifo_clear,
  input  logic                 qeu_next,
  input  logic [PTR_WIDTH-1:0] qeu_read_addr,
  output logic [WIDTH-1:0]     dataout_qeu,
  output logic                 qeu_ready,
  output logic [PTR_WIDTH:0]   qeu_rd_len,
  output logic                 mem_busy,
  output logic                 load_done,
  output logic                 load_err,
  output logic [CNT_WIDTH-1:0] fill_count,
  output logic [1:0]           dbug_load_state,
  output logic [PTR_WIDTH-1:0] dbug_wr_addr
);

  localparam int BIDX_W = bank_idx_w(NUM_BANKS);
  localparam logic [BIDX_W-1:0]    LAST_BANK = BIDX_W'(NUM_BANKS - 1);
  localparam logic [BIDX_W-1:0]    BANK_ONE  = BIDX_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(NUM_BANKS);
  localparam logic [PTR_WIDTH:0]   LEN_ONE   = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH:0]   LEN_MAX   = (PTR_WIDTH + 1)'(QEU_DEPTH);

  function automatic logic [BIDX_W-1:0] bank_inc(input logic [BIDX_W-1:0] b);
    return (b == LAST_BANK) ? '0 : b + BANK_ONE;
  endfunction

  load_state_e state_q, state_d;
  // Counts words written; one bit wider than the RAM address so it can reach len.
  logic [PTR_WIDTH:0]   wr_addr_q, wr_addr_d;
  logic [PTR_WIDTH:0]   len_q, len_d;
  logic [BIDX_W-1:0]    wr_bank_q, wr_bank_d;
  logic [BIDX_W-1:0]    rd_bank_q, rd_bank_d;
  // Bank whose RAM output is on dataout_qeu (rd_bank as of the address cycle).
  logic [BIDX_W-1:0]    rd_sel_q, rd_sel_d;
  logic [CNT_WIDTH-1:0] fill_q, fill_d;
  logic [NUM_BANKS-1:0] full_q, full_d;
  logic [PTR_WIDTH:0]   blen_q [NUM_BANKS];
  logic [PTR_WIDTH:0]   blen_d [NUM_BANKS];
  logic                 load_err_q, load_err_d;
  logic                 done_q, done_d;
  logic                 clear_q, clear_d;

  logic                 len_ok;
  logic                 commit;
  logic                 rel_ok;
  logic [WIDTH-1:0]     ram_dout [NUM_BANKS];
  logic                 unused_fifo_bits;

  assign unused_fifo_bits = ^src_fifo_data;
  assign len_ok = (load_len != '0) && (load_len <= LEN_MAX);

  // Load FSM, ring bookkeeping and error/pulse generation.
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    len_d         = len_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    rd_sel_d      = rd_bank_q;
    fill_d        = fill_q;
    full_d        = full_q;
    blen_d        = blen_q;
    load_err_d    = load_err_q;
    done_d        = 1'b0;
    clear_d       = 1'b0;
    commit        = 1'b0;
    rel_ok        = 1'b0;
    src_fifo_rden = 1'b0;

    if (load_cmd && (!len_ok || mem_busy)) begin
      load_err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (load_cmd && !mem_busy && len_ok) begin
          state_d   = ST_LOAD;
          len_d     = load_len;
          wr_addr_d = '0;
        end
      end
      ST_LOAD: begin
        src_fifo_rden = !src_fifo_empty && (wr_addr_q < len_q);
        if (load_abort) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (src_fifo_rden) begin
          wr_addr_d = wr_addr_q + LEN_ONE;
          if (wr_addr_q == len_q - LEN_ONE) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        commit            = 1'b1;
        full_d[wr_bank_q] = 1'b1;
        blen_d[wr_bank_q] = len_q;
        done_d            = 1'b1;
        wr_bank_d         = bank_inc(wr_bank_q);
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The read bank is always full when fill_q != 0 and the bank being
    // committed never is, so the two full_d updates never collide.
    if (qeu_next) begin
      if (fill_q != '0) begin
        rel_ok            = 1'b1;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = bank_inc(rd_bank_q);
      end else begin
        load_err_d = 1'b1;
      end
    end

    unique case ({commit, rel_ok})
      2'b10:   fill_d = fill_q + CNT_ONE;
      2'b01:   fill_d = fill_q - CNT_ONE;
      default: fill_d = fill_q;
    endcase
  end

  // State and bookkeeping registers; reset drops any partial or held bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      len_q      <= '0;
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      rd_sel_q   <= '0;
      fill_q     <= '0;
      full_q     <= '0;
      load_err_q <= 1'b0;
      done_q     <= 1'b0;
      clear_q    <= 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        blen_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      len_q      <= len_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_sel_q   <= rd_sel_d;
      fill_q     <= fill_d;
      full_q     <= full_d;
      load_err_q <= load_err_d;
      done_q     <= done_d;
      clear_q    <= clear_d;
      blen_q     <= blen_d;
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic                 sel_wr;
    logic [PTR_WIDTH-1:0] addr;
    assign sel_wr = (state_q == ST_LOAD) && (wr_bank_q == BIDX_W'(gi));
    assign addr   = sel_wr ? wr_addr_q[PTR_WIDTH-1:0] : qeu_read_addr;

    qeu_bank_ram #(
      .WIDTH (WIDTH),
      .DEPTH (QEU_DEPTH),
      .AW    (PTR_WIDTH)
    ) u_ram (
      .clk  (clk),
      .we   (sel_wr && src_fifo_rden),
      .addr (addr),
      .din  (src_fifo_data[WIDTH-1:0]),
      .dout (ram_dout[gi])
    );
  end

  assign dataout_qeu     = ram_dout[rd_sel_q];
  assign qeu_ready       = (fill_q != '0);
  assign mem_busy        = (fill_q == CNT_FULL);
  assign qeu_rd_len      = full_q[rd_bank_q] ? blen_q[rd_bank_q] : '0;
  assign load_done       = done_q;
  assign load_err        = load_err_q;
  assign src_fifo_clear  = clear_q;
  assign fill_count      = fill_q;
  assign dbug_load_state = state_q;
  assign dbug_wr_addr    = wr_addr_q[PTR_WIDTH-1:0];

endmodule

// File: tb/tb_qeu_bank_mem.sv
// Directed bench for qeu_bank_mem with 3 banks of 16 x 16-bit words.
module tb_qeu_bank_mem;

  localparam int WIDTH     = 16;
  localparam int NUM_BANKS = 3;
  localparam int QEU_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_cmd = 1'b0;
  logic [4:0]  load_len = '0;
  logic        load_abort = 1'b0;
  logic        src_fifo_empty = 1'b1;
  logic [31:0] src_fifo_data;
  logic        src_fifo_rden;
  logic        src_fifo_clear;
  logic        qeu_next = 1'b0;
  logic [3:0]  qeu_read_addr = '0;
  logic [15:0] dataout_qeu;
  logic        qeu_ready;
  logic [4:0]  qeu_rd_len;
  logic        mem_busy;
  logic        load_done;
  logic        load_err;
  logic [1:0]  fill_count;
  logic [1:0]  dbug_load_state;
  logic [3:0]  dbug_wr_addr;

  qeu_bank_mem #(
    .WIDTH     (WIDTH),
    .NUM_BANKS (NUM_BANKS),
    .QEU_DEPTH (QEU_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .load_cmd        (load_cmd),
    .load_len        (load_len),
    .load_abort      (load_abort),
    .src_fifo_empty  (src_fifo_empty),
    .src_fifo_data   (src_fifo_data),
    .src_fifo_rden   (src_fifo_rden),
    .src_fifo_clear  (src_fifo_clear),
    .qeu_next        (qeu_next),
    .qeu_read_addr   (qeu_read_addr),
    .dataout_qeu     (dataout_qeu),
    .qeu_ready       (qeu_ready),
    .qeu_rd_len      (qeu_rd_len),
    .mem_busy        (mem_busy),
    .load_done       (load_done),
    .load_err        (load_err),
    .fill_count      (fill_count),
    .dbug_load_state (dbug_load_state),
    .dbug_wr_addr    (dbug_wr_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // FIFO model: head word is fifo_base + (words consumed since fifo_start).
  int          rden_cnt = 0;
  int          bad_rden = 0;
  int          done_cnt = 0;
  int          clear_cnt = 0;
  logic [15:0] fifo_base = '0;
  int          fifo_start = 0;

  assign src_fifo_data = {16'h0000, fifo_base + 16'(rden_cnt - fifo_start)};

  always @(posedge clk) begin
    if (src_fifo_rden) rden_cnt <= rden_cnt + 1;
    if (src_fifo_rden && src_fifo_empty) bad_rden <= bad_rden + 1;
    if (load_done) done_cnt <= done_cnt + 1;
    if (src_fifo_clear) clear_cnt <= clear_cnt + 1;
  end

  typedef struct packed {
    logic [4:0] len;
    logic [1:0] st;
    logic       err;
  } leg_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } rd_t;

  leg_t leg_tab [5];
  rd_t  rd_tab  [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load_cmd = 1'b0;
    load_abort = 1'b0;
    qeu_next = 1'b0;
    src_fifo_empty = 1'b1;
    qeu_read_addr = '0;
    load_len = '0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // Issue a load and wait (bounded) for load_done; lat = edges from cmd to pulse.
  task automatic do_load(input logic [4:0] len, input logic [15:0] base, input logic gap,
                         output int lat);
    int n;
    logic got;
    fifo_base = base;
    fifo_start = rden_cnt;
    src_fifo_empty = gap;
    load_len = len;
    load_cmd = 1'b1;
    cyc();
    load_cmd = 1'b0;
    n = 1;
    got = 1'b0;
    while (!got && n < 80) begin
      if (gap) src_fifo_empty = ~src_fifo_empty;
      cyc();
      n++;
      got = load_done;
    end
    src_fifo_empty = 1'b1;
    lat = n;
    chk("load_done_within_budget", 32'(got), 32'd1);
  endtask

  task automatic rd(input logic [3:0] addr, input logic [15:0] exp, input string nm);
    qeu_read_addr = addr;
    cyc();
    chk(nm, 32'(dataout_qeu), 32'(exp));
  endtask

  task automatic pulse_next();
    qeu_next = 1'b1;
    cyc();
    qeu_next = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int r0;
    int b0;
    int c0;
    int d0;

    leg_tab[0] = '{len: 5'd0,  st: 2'd0, err: 1'b1};
    leg_tab[1] = '{len: 5'd17, st: 2'd0, err: 1'b1};
    leg_tab[2] = '{len: 5'd31, st: 2'd0, err: 1'b1};
    leg_tab[3] = '{len: 5'd1,  st: 2'd1, err: 1'b0};
    leg_tab[4] = '{len: 5'd16, st: 2'd1, err: 1'b0};

    rd_tab[0] = '{addr: 4'd0,  data: 16'h0100};
    rd_tab[1] = '{addr: 4'd15, data: 16'h010F};
    rd_tab[2] = '{addr: 4'd10, data: 16'h010A};
    rd_tab[3] = '{addr: 4'd1,  data: 16'h0101};

    // Reset state
    do_reset();
    chk("rst_state", 32'(dbug_load_state), 0);
    chk("rst_fill", 32'(fill_count), 0);
    chk("rst_ready", 32'(qeu_ready), 0);
    chk("rst_busy", 32'(mem_busy), 0);
    chk("rst_err", 32'(load_err), 0);
    chk("rst_rden", 32'(src_fifo_rden), 0);
    chk("rst_clear", 32'(src_fifo_clear), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_rd_len", 32'(qeu_rd_len), 0);
    chk("rst_wr_addr", 32'(dbug_wr_addr), 0);

    // Full-depth load, FIFO always ready
    r0 = rden_cnt;
    do_load(5'd16, 16'h0100, 1'b0, lat);
    chk("s1_done_latency", 32'(lat), 18);
    chk("s1_rden_cycles", 32'(rden_cnt - r0), 16);
    chk("s1_fill", 32'(fill_count), 1);
    chk("s1_ready", 32'(qeu_ready), 1);
    chk("s1_rd_len", 32'(qeu_rd_len), 16);
    chk("s1_state_idle", 32'(dbug_load_state), 0);
    rd(4'd5, 16'h0105, "s1_read_addr5");
    chk("s1_done_one_cycle", 32'(load_done), 0);
    for (int i = 0; i < 4; i++) begin
      rd(rd_tab[i].addr, rd_tab[i].data, "s1_read_table");
    end

    // load_cmd length legality
    for (int i = 0; i < 5; i++) begin
      do_reset();
      load_len = leg_tab[i].len;
      load_cmd = 1'b1;
      cyc();
      load_cmd = 1'b0;
      chk("leg_state", 32'(dbug_load_state), 32'(leg_tab[i].st));
      chk("leg_err", 32'(load_err), 32'(leg_tab[i].err));
    end

    // qeu_next with nothing held
    do_reset();
    pulse_next();
    chk("empty_next_err", 32'(load_err), 1);
    chk("empty_next_fill", 32'(fill_count), 0);
    cyc();
    chk("err_sticky", 32'(load_err), 1);

    // Fill all banks, overflow attempt, drain
    do_reset();
    do_load(5'd4, 16'h0200, 1'b0, lat);
    do_load(5'd7, 16'h0300, 1'b0, lat);
    do_load(5'd16, 16'h0400, 1'b0, lat);
    chk("s2_fill3", 32'(fill_count), 3);
    chk("s2_busy", 32'(mem_busy), 1);
    chk("s2_err_before", 32'(load_err), 0);
    src_fifo_empty = 1'b0;
    load_len = 5'd2;
    load_cmd = 1'b1;
    cyc();
    load_cmd = 1'b0;
    src_fifo_empty = 1'b1;
    chk("s2_fourth_ignored", 32'(dbug_load_state), 0);
    chk("s2_fourth_err", 32'(load_err), 1);
    chk("s2_fill_still3", 32'(fill_count), 3);
    chk("s2_len_a", 32'(qeu_rd_len), 4);
    rd(4'd3, 16'h0203, "s2_read_a");
    pulse_next();
    chk("s2_len_b", 32'(qeu_rd_len), 7);
    chk("s2_busy_clear", 32'(mem_busy), 0);
    rd(4'd6, 16'h0306, "s2_read_b");
    pulse_next();
    chk("s2_len_c", 32'(qeu_rd_len), 16);
    rd(4'd15, 16'h040F, "s2_read_c");
    pulse_next();
    chk("s2_drained_fill", 32'(fill_count), 0);
    chk("s2_drained_ready", 32'(qeu_ready), 0);
    chk("s2_drained_len", 32'(qeu_rd_len), 0);

    // FIFO stalling every other cycle
    do_reset();
    r0 = rden_cnt;
    b0 = bad_rden;
    do_load(5'd8, 16'h0500, 1'b1, lat);
    chk("s3_rden_count", 32'(rden_cnt - r0), 8);
    chk("s3_no_rden_when_empty", 32'(bad_rden - b0), 0);
    for (int i = 0; i < 8; i++) begin
      rd(4'(i), 16'h0500 + 16'(i), "s3_order");
    end

    // Abort after three words
    do_reset();
    c0 = clear_cnt;
    d0 = done_cnt;
    fifo_base = 16'h0600;
    fifo_start = rden_cnt;
    src_fifo_empty = 1'b0;
    load_len = 5'd8;
    load_cmd = 1'b1;
    cyc();
    load_cmd = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("s4_words_before_abort", 32'(dbug_wr_addr), 3);
    load_abort = 1'b1;
    src_fifo_empty = 1'b1;
    cyc();
    load_abort = 1'b0;
    chk("s4_state_idle", 32'(dbug_load_state), 0);
    chk("s4_clear_pulse", 32'(src_fifo_clear), 1);
    cyc();
    chk("s4_clear_low", 32'(src_fifo_clear), 0);
    chk("s4_clear_once", 32'(clear_cnt - c0), 1);
    chk("s4_fill_unchanged", 32'(fill_count), 0);
    chk("s4_no_commit", 32'(done_cnt - d0), 0);
    chk("s4_reads", 32'(rden_cnt - fifo_start), 3);
    do_load(5'd2, 16'h0700, 1'b0, lat);
    chk("s4_next_fill", 32'(fill_count), 1);
    rd(4'd1, 16'h0701, "s4_same_bank_w1");
    rd(4'd0, 16'h0700, "s4_same_bank_w0");

    // Commit coincident with release at fill_count=2, both indices wrapping
    do_reset();
    do_load(5'd2, 16'h0800, 1'b0, lat);
    do_load(5'd3, 16'h0900, 1'b0, lat);
    do_load(5'd4, 16'h0A00, 1'b0, lat);
    pulse_next();
    pulse_next();
    do_load(5'd5, 16'h0D00, 1'b0, lat);
    chk("s5_fill_pre", 32'(fill_count), 2);
    chk("s5_len_pre", 32'(qeu_rd_len), 4);
    fifo_base = 16'h0E00;
    fifo_start = rden_cnt;
    src_fifo_empty = 1'b0;
    load_len = 5'd6;
    load_cmd = 1'b1;
    cyc();
    load_cmd = 1'b0;
    n = 0;
    while (dbug_load_state != 2'd2 && n < 40) begin
      cyc();
      n++;
    end
    chk("s5_reached_done", 32'(dbug_load_state), 2);
    qeu_next = 1'b1;
    cyc();
    qeu_next = 1'b0;
    src_fifo_empty = 1'b1;
    chk("s5_done_pulse", 32'(load_done), 1);
    chk("s5_fill_kept", 32'(fill_count), 2);
    chk("s5_rd_wrap_len", 32'(qeu_rd_len), 5);
    rd(4'd4, 16'h0D04, "s5_wr_wrap_data");
    pulse_next();
    chk("s5_len_e", 32'(qeu_rd_len), 6);
    chk("s5_fill1", 32'(fill_count), 1);
    rd(4'd5, 16'h0E05, "s5_read_e");

    // Asynchronous reset in the middle of a load
    do_reset();
    do_load(5'd3, 16'h0C00, 1'b0, lat);
    fifo_base = 16'h0F00;
    fifo_start = rden_cnt;
    src_fifo_empty = 1'b0;
    load_len = 5'd8;
    load_cmd = 1'b1;
    cyc();
    load_cmd = 1'b0;
    repeat (5) cyc();
    chk("s6_word5", 32'(dbug_wr_addr), 5);
    chk("s6_fill_pre", 32'(fill_count), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_async_state", 32'(dbug_load_state), 0);
    chk("s6_async_rden", 32'(src_fifo_rden), 0);
    chk("s6_async_wr_addr", 32'(dbug_wr_addr), 0);
    chk("s6_async_fill", 32'(fill_count), 0);
    chk("s6_async_ready", 32'(qeu_ready), 0);
    chk("s6_async_rd_len", 32'(qeu_rd_len), 0);
    chk("s6_async_busy", 32'(mem_busy), 0);
    chk("s6_async_done", 32'(load_done), 0);
    chk("s6_async_clear", 32'(src_fifo_clear), 0);
    chk("s6_async_err", 32'(load_err), 0);
    src_fifo_empty = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    do_load(5'd2, 16'h0B00, 1'b0, lat);
    chk("s6_fill_after", 32'(fill_count), 1);
    chk("s6_len_after", 32'(qeu_rd_len), 2);
    rd(4'd1, 16'h0B01, "s6_bank0_w1");
    rd(4'd0, 16'h0B00, "s6_bank0_w0");

    chk("global_no_rden_when_empty", 32'(bad_rden), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
